// File: rtl/pipe_mem_stage.sv
// MEM stage: EX/MEM and MEM/WB registers plus a req/ack master toward a variable-latency data memory.
// One cycle per register; mstall freezes upstream while an aligned load/store waits for d_ack or times out.
module pipe_mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic [31:0] ealu,
  input  logic [31:0] eb,
  input  logic [4:0]  ern,
  output logic        d_req,
  output logic        d_we,
  output logic [31:0] d_addr,
  output logic [31:0] d_wdata,
  input  logic        d_ack,
  input  logic [31:0] d_rdata,
  output logic        mstall,
  output logic        mwreg,
  output logic        mm2reg,
  output logic [31:0] malu,
  output logic [4:0]  mrn,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn,
  output logic        wexc,
  output logic        bus_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        mwreg_q, mm2reg_q, mwmem_q;
  logic [31:0] malu_q, mb_q;
  logic [4:0]  mrn_q;
  logic        wwreg_q, wm2reg_q, wexc_q, bus_err_q;
  logic [31:0] wmo_q, walu_q;
  logic [4:0]  wrn_q;

  logic memop, mis, pend, abort, ack_v, stall;

  always_comb begin
    memop = mm2reg_q | mwmem_q;
    mis   = memop & (malu_q[1:0] != 2'b00);
    pend  = memop & ~mis;
    ack_v = pend & d_ack;
    abort = pend & (cnt_q == CNT_LAST) & ~d_ack;
    stall = pend & ~d_ack & ~abort;
  end

  // cnt holds the index of the current request cycle, so the TIMEOUT-th one sees TIMEOUT-1
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE:    if (stall) state_d = BUSY;
      BUSY:    if (!stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == BUSY) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mwreg_q   <= 1'b0;
      mm2reg_q  <= 1'b0;
      mwmem_q   <= 1'b0;
      malu_q    <= '0;
      mb_q      <= '0;
      mrn_q     <= '0;
      wwreg_q   <= 1'b0;
      wm2reg_q  <= 1'b0;
      wexc_q    <= 1'b0;
      wmo_q     <= '0;
      walu_q    <= '0;
      wrn_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (abort) bus_err_q <= 1'b1;
      if (stall) begin
        wwreg_q <= 1'b0;
        wexc_q  <= 1'b0;
      end else begin
        wwreg_q  <= mwreg_q & ~mis;
        wexc_q   <= mis;
        wm2reg_q <= mm2reg_q;
        walu_q   <= malu_q;
        wrn_q    <= mrn_q;
        if (ack_v & mm2reg_q) wmo_q <= d_rdata;
        else if (abort)       wmo_q <= '0;
        mwreg_q  <= ewreg;
        mm2reg_q <= em2reg;
        mwmem_q  <= ewmem;
        malu_q   <= ealu;
        mb_q     <= eb;
        mrn_q    <= ern;
      end
    end
  end

  assign d_req   = pend;
  assign d_we    = mwmem_q;
  assign d_addr  = malu_q;
  assign d_wdata = mb_q;
  assign mstall  = stall;
  assign mwreg   = mwreg_q;
  assign mm2reg  = mm2reg_q;
  assign malu    = malu_q;
  assign mrn     = mrn_q;
  assign wwreg   = wwreg_q;
  assign wm2reg  = wm2reg_q;
  assign wmo     = wmo_q;
  assign walu    = walu_q;
  assign wrn     = wrn_q;
  assign wexc    = wexc_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Directed bench for pipe_mem_stage: per-cycle reference model plus hand-computed checks per scenario.
module tb_pipe_mem_stage;
  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        ewreg = 1'b0, em2reg = 1'b0, ewmem = 1'b0;
  logic [31:0] ealu = '0, eb = '0;
  logic [4:0]  ern = '0;
  logic        d_ack = 1'b0;
  logic [31:0] d_rdata = '0;

  logic        d_req, d_we, mstall, mwreg, mm2reg, wwreg, wm2reg, wexc, bus_err;
  logic [31:0] d_addr, d_wdata, malu, wmo, walu;
  logic [4:0]  mrn, wrn;

  pipe_mem_stage #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clock(clock), .resetn(resetn),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ealu(ealu), .eb(eb), .ern(ern),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .mstall(mstall),
    .mwreg(mwreg), .mm2reg(mm2reg), .malu(malu), .mrn(mrn),
    .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu), .wrn(wrn),
    .wexc(wexc), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the instruction sitting in MEM, how many request cycles it has used, and the WB slot
  logic        r_wreg = 0, r_m2reg = 0, r_wmem = 0;
  logic [31:0] r_alu = 0, r_b = 0;
  logic [4:0]  r_rn = 0;
  int          waited = 0;
  logic        r_wwreg = 0, r_wm2reg = 0, r_wexc = 0, r_berr = 0;
  logic [31:0] r_wmo = 0, r_walu = 0;
  logic [4:0]  r_wrn = 0;

  logic r_mis, r_req, r_ack, r_abort, r_stall;
  always_comb begin
    r_mis   = (r_m2reg || r_wmem) && (r_alu % 4 != 0);
    r_req   = (r_m2reg || r_wmem) && !r_mis;
    r_ack   = r_req && d_ack;
    r_abort = r_req && !d_ack && (waited + 1 == TO);
    r_stall = r_req && !d_ack && !r_abort;
  end

  always @(posedge clock) begin
    logic st, ab, ak, ms;
    st = r_stall; ab = r_abort; ak = r_ack; ms = r_mis;
    if (!resetn) begin
      r_wreg = 0; r_m2reg = 0; r_wmem = 0; r_alu = 0; r_b = 0; r_rn = 0; waited = 0;
      r_wwreg = 0; r_wm2reg = 0; r_wexc = 0; r_berr = 0; r_wmo = 0; r_walu = 0; r_wrn = 0;
    end else begin
      if (ab) r_berr = 1;
      if (st) begin
        waited = waited + 1;
        r_wwreg = 0;
        r_wexc = 0;
      end else begin
        waited = 0;
        r_wwreg = r_wreg && !ms;
        r_wexc = ms;
        r_wm2reg = r_m2reg;
        r_walu = r_alu;
        r_wrn = r_rn;
        if (ak && r_m2reg) r_wmo = d_rdata;
        else if (ab) r_wmo = 0;
        r_wreg = ewreg; r_m2reg = em2reg; r_wmem = ewmem;
        r_alu = ealu; r_b = eb; r_rn = ern;
      end
    end
  end

  logic started = 1'b0;
  always @(negedge clock) begin
    if (started) begin
      chk("d_req", d_req, r_req);
      chk("d_we", d_we, r_wmem);
      chk("d_addr", d_addr, r_alu);
      chk("d_wdata", d_wdata, r_b);
      chk("mstall", mstall, r_stall);
      chk("mwreg", mwreg, r_wreg);
      chk("mm2reg", mm2reg, r_m2reg);
      chk("malu", malu, r_alu);
      chk("mrn", mrn, r_rn);
      chk("wwreg", wwreg, r_wwreg);
      chk("wm2reg", wm2reg, r_wm2reg);
      chk("wmo", wmo, r_wmo);
      chk("walu", walu, r_walu);
      chk("wrn", wrn, r_wrn);
      chk("wexc", wexc, r_wexc);
      chk("bus_err", bus_err, r_berr);
    end
  end

  int          req_n = 0, stall_n = 0;
  logic [31:0] last_addr = 0, last_wdata = 0;
  logic        last_we = 0;

  task automatic cyc();
    @(negedge clock);
    if (d_req) begin
      req_n++;
      last_addr = d_addr;
      last_wdata = d_wdata;
      last_we = d_we;
    end
    if (mstall) stall_n++;
    @(posedge clock);
    #1;
  endtask

  task automatic set_e(input logic w, input logic l, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rn);
    ewreg = w; em2reg = l; ewmem = s; ealu = a; eb = b; ern = rn;
  endtask

  task automatic clr();
    req_n = 0;
    stall_n = 0;
  endtask

  initial begin
    resetn = 1'b0;
    cyc(); cyc();
    started = 1'b1;
    chk("rst_d_req", d_req, 0);
    chk("rst_mstall", mstall, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_wmo", wmo, 0);
    chk("rst_mrn", mrn, 0);
    resetn = 1'b1;

    // Load with the ack arriving in the fourth request cycle
    set_e(1, 1, 0, 32'h100, 0, 5'd7); cyc();
    set_e(0, 0, 0, 0, 0, 0); clr();
    repeat (3) cyc();
    d_ack = 1; d_rdata = 32'hDEADBEEF; cyc();
    d_ack = 0; d_rdata = 0;
    chk("t1_stall_cycles", stall_n, 3);
    chk("t1_req_cycles", req_n, 4);
    chk("t1_we", last_we, 0);
    chk("t1_addr", last_addr, 32'h100);
    chk("t1_wmo", wmo, 32'hDEADBEEF);
    chk("t1_wwreg", wwreg, 1);
    chk("t1_wm2reg", wm2reg, 1);
    chk("t1_wrn", wrn, 7);

    // Store with zero-wait ack
    set_e(0, 0, 1, 32'h20, 32'h12345678, 0); cyc();
    set_e(0, 0, 0, 0, 0, 0); clr();
    d_ack = 1; cyc();
    d_ack = 0;
    chk("t2_wwreg", wwreg, 0);
    chk("t2_wexc", wexc, 0);
    cyc();
    chk("t2_req_cycles", req_n, 1);
    chk("t2_stall_cycles", stall_n, 0);
    chk("t2_we", last_we, 1);
    chk("t2_addr", last_addr, 32'h20);
    chk("t2_wdata", last_wdata, 32'h12345678);
    chk("t2_wmo_held", wmo, 32'hDEADBEEF);

    // Back-to-back ALU ops
    clr();
    set_e(1, 0, 0, 32'h13, 0, 5'd3); cyc();
    chk("t3_mrn3", mrn, 3);
    set_e(1, 0, 0, 32'h14, 0, 5'd4); cyc();
    chk("t3_mrn4", mrn, 4);
    chk("t3_wrn3", wrn, 3);
    set_e(1, 0, 0, 32'h15, 0, 5'd5); cyc();
    chk("t3_mrn5", mrn, 5);
    chk("t3_wrn4", wrn, 4);
    set_e(0, 0, 0, 0, 0, 0); cyc();
    chk("t3_wrn5", wrn, 5);
    chk("t3_walu", walu, 32'h15);
    chk("t3_wwreg", wwreg, 1);
    chk("t3_stall_cycles", stall_n, 0);
    chk("t3_req_cycles", req_n, 0);

    // Misaligned load
    clr();
    set_e(1, 1, 0, 32'h102, 0, 5'd9); cyc();
    set_e(0, 0, 0, 0, 0, 0); cyc();
    chk("t4_wexc", wexc, 1);
    chk("t4_wwreg", wwreg, 0);
    chk("t4_wrn", wrn, 9);
    cyc();
    chk("t4_wexc_clear", wexc, 0);
    chk("t4_req_cycles", req_n, 0);
    chk("t4_stall_cycles", stall_n, 0);

    // Load that never gets an ack
    set_e(1, 1, 0, 32'h200, 0, 5'd10); cyc();
    set_e(0, 0, 0, 0, 0, 0); clr();
    repeat (16) cyc();
    chk("t5_stall_cycles", stall_n, 15);
    chk("t5_req_cycles", req_n, 16);
    chk("t5_wmo", wmo, 0);
    chk("t5_bus_err", bus_err, 1);
    chk("t5_wwreg", wwreg, 1);
    chk("t5_wrn", wrn, 10);
    cyc(); cyc();
    chk("t5_bus_err_held", bus_err, 1);
    chk("t5_req_dropped", d_req, 0);

    // Reset in the middle of an outstanding load
    set_e(1, 1, 0, 32'h300, 0, 5'd12); cyc();
    set_e(0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    chk("t6_busy_req", d_req, 1);
    chk("t6_busy_stall", mstall, 1);
    resetn = 1'b0; cyc();
    chk("t6_d_req", d_req, 0);
    chk("t6_mstall", mstall, 0);
    chk("t6_mwreg", mwreg, 0);
    chk("t6_malu", malu, 0);
    chk("t6_mrn", mrn, 0);
    chk("t6_wwreg", wwreg, 0);
    chk("t6_walu", walu, 0);
    chk("t6_wrn", wrn, 0);
    chk("t6_bus_err", bus_err, 0);
    resetn = 1'b1;
    d_ack = 1; d_rdata = 32'hCAFEF00D; cyc();
    d_ack = 0; d_rdata = 0;
    chk("t6_late_ack_wmo", wmo, 0);
    chk("t6_late_ack_req", d_req, 0);
    chk("t6_late_ack_wwreg", wwreg, 0);
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
